// File: rtl/uart_rx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Received-byte bundle from the UART receiver to its consumer.
// Revision : 1.0
// ============================================================================
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] o_data;
  logic                 o_valid;
  logic                 o_frame_err;
  logic                 o_busy;

  modport master (output o_data, output o_valid, output o_frame_err, output o_busy);
  modport slave  (input  o_data, input  o_valid, input  o_frame_err, input  o_busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, one-cycle valid/frame-error strobes.
// Revision : 1.0
// ============================================================================
module uart_rx #(
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int DATA_BITS   = 8
) (
  input wire        sysclk,
  input wire        rst,
  input wire        i_en,
  input wire        i_rx,
  uart_rx_if.master rx_if
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] c_LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] c_BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
  } state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [CNT_W-1:0]     r_clk_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_frame_err;

  state_t               w_state_nxt;
  logic [CNT_W-1:0]     w_clk_cnt_nxt;
  logic [BIT_W-1:0]     w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_valid_nxt;
  logic                 w_frame_err_nxt;
  logic                 w_bit_done;

  assign w_bit_done = (r_clk_cnt == c_BIT_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_clk_cnt_nxt   = r_clk_cnt + c_CNT_ONE;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_data_nxt      = r_data;
    w_valid_nxt     = 1'b0;
    w_frame_err_nxt = 1'b0;

    if (!i_en) begin
      // Disabling abandons any partial frame without a strobe.
      w_state_nxt   = S_IDLE;
      w_clk_cnt_nxt = '0;
      w_bit_cnt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
          if (!r_rx_s) w_state_nxt = S_START;
        end
        S_START: begin
          if (r_clk_cnt == c_HALF_LAST) begin
            w_clk_cnt_nxt = '0;
            w_state_nxt   = r_rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            w_clk_cnt_nxt = '0;
            w_shift_nxt   = {r_rx_s, r_shift[DATA_BITS-1:1]};
            w_bit_cnt_nxt = r_bit_cnt + c_BIT_ONE;
            if (r_bit_cnt == c_LAST_DATA) w_state_nxt = S_STOP;
          end
        end
        S_STOP: begin
          // Leaving at mid-stop-bit lets an immediately following start bit be caught.
          if (w_bit_done) begin
            w_clk_cnt_nxt = '0;
            w_bit_cnt_nxt = '0;
            if (r_rx_s) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_frame_err_nxt = 1'b1;
              w_state_nxt     = S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          w_clk_cnt_nxt = '0;
          if (r_rx_s) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_clk_cnt_nxt = '0;
          w_bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_meta   <= i_rx;
      r_rx_s      <= r_rx_meta;
      r_state     <= w_state_nxt;
      r_clk_cnt   <= w_clk_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
  end

  assign rx_if.o_data      = r_data;
  assign rx_if.o_valid     = r_valid;
  assign rx_if.o_frame_err = r_frame_err;
  assign rx_if.o_busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Random and directed frames against a frame-level scoreboard.
// Revision : 1.0
// ============================================================================
module tb_uart_rx;

  localparam int LAT_MIN = 95;
  localparam int LAT_MAX = 99;

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
    int         t0;
  } exp_t;

  logic sysclk = 1'b0;
  logic rst;
  logic i_en;
  logic i_rx;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] model_last;
  exp_t exp_q[$];

  uart_rx_if #(.DATA_BITS(8)) rx_if ();

  uart_rx #(
    .CLK_FREQ_HZ(125_000_000),
    .BAUD_RATE  (12_500_000),
    .DATA_BITS  (8)
  ) dut (
    .sysclk(sysclk),
    .rst   (rst),
    .i_en  (i_en),
    .i_rx  (i_rx),
    .rx_if (rx_if)
  );

  always #4 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expected frame.
  always @(negedge sysclk) begin
    if (rx_if.o_valid || rx_if.o_frame_err) begin
      check("strobe_exclusive", {31'd0, rx_if.o_valid & rx_if.o_frame_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", {31'd0, rx_if.o_frame_err}, {31'd0, ~rx_if.o_valid});
        check("unexpected_strobe_count", 32'd1, 32'd0 + 32'(exp_q.size()));
      end else begin
        exp_t e;
        int   lat;
        e   = exp_q.pop_front();
        lat = cyc - e.t0;
        check("strobe_kind_err", {31'd0, rx_if.o_frame_err}, {31'd0, e.is_err});
        check("strobe_data", {24'd0, rx_if.o_data}, {24'd0, e.data});
        if (lat < LAT_MIN || lat > LAT_MAX)
          check("strobe_latency", lat, 97);
        else
          check("strobe_latency_window", 32'd1, {31'd0, (lat >= LAT_MIN && lat <= LAT_MAX)});
      end
    end
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    i_rx = b;
    repeat (n) tick();
  endtask

  // Reference: a frame yields valid+data when its stop bit is 1, otherwise a
  // frame error with the previously received byte still on o_data.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t       e;
    logic [9:0] fr;
    fr       = {stop, d, 1'b0};
    e.t0     = cyc;
    e.is_err = ~stop;
    e.data   = stop ? d : model_last;
    if (stop) model_last = d;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) drive(fr[i], 10);
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    for (int i = 0; i <= nbits; i++) drive(fr[i], 10);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_busy;
    logic stop;
    logic [7:0] d;

    rst = 1'b1; i_en = 1'b0; i_rx = 1'b1; model_last = 8'h00;
    repeat (3) tick();
    check("reset_data",  {24'd0, rx_if.o_data}, 32'h00);
    check("reset_valid", {31'd0, rx_if.o_valid}, 32'd0);
    check("reset_ferr",  {31'd0, rx_if.o_frame_err}, 32'd0);
    check("reset_busy",  {31'd0, rx_if.o_busy}, 32'd0);
    rst = 1'b0; i_en = 1'b1;
    repeat (20) tick();
    check("idle_busy", {31'd0, rx_if.o_busy}, 32'd0);

    send_frame(8'hA5, 1'b1);
    drive(1'b1, 20);
    drain(50);

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    drive(1'b1, 5);
    drain(50);

    drive(1'b0, 3);
    i_rx = 1'b1;
    saw_busy = 1'b0;
    repeat (15) begin
      tick();
      if (rx_if.o_busy) saw_busy = 1'b1;
    end
    check("glitch_busy_seen", {31'd0, saw_busy}, 32'd1);
    check("glitch_back_idle", {31'd0, rx_if.o_busy}, 32'd0);
    send_frame(8'h3C, 1'b1);
    drive(1'b1, 5);
    drain(50);

    send_frame(8'h5A, 1'b1);
    send_frame(8'h3C, 1'b0);
    drive(1'b0, 30);
    check("break_busy_held", {31'd0, rx_if.o_busy}, 32'd1);
    drive(1'b1, 5);
    check("break_released", {31'd0, rx_if.o_busy}, 32'd0);
    check("break_data_kept", {24'd0, rx_if.o_data}, 32'h5A);
    drain(50);
    send_frame(8'h81, 1'b1);
    drive(1'b1, 5);
    drain(50);

    send_partial(8'h77, 4);
    check("abort_en_busy_before", {31'd0, rx_if.o_busy}, 32'd1);
    i_en = 1'b0;
    tick();
    check("abort_en_busy_after", {31'd0, rx_if.o_busy}, 32'd0);
    check("abort_en_data_kept", {24'd0, rx_if.o_data}, {24'd0, model_last});
    i_rx = 1'b1;
    repeat (20) tick();
    i_en = 1'b1;
    repeat (5) tick();

    send_partial(8'h77, 4);
    check("abort_rst_busy_before", {31'd0, rx_if.o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    model_last = 8'h00;
    check("abort_rst_data",  {24'd0, rx_if.o_data}, 32'h00);
    check("abort_rst_busy",  {31'd0, rx_if.o_busy}, 32'd0);
    check("abort_rst_valid", {31'd0, rx_if.o_valid}, 32'd0);
    check("abort_rst_ferr",  {31'd0, rx_if.o_frame_err}, 32'd0);
    i_rx = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (10) tick();

    for (int k = 0; k < 24; k++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_frame(d, stop);
      if (!stop) begin
        drive(1'b0, $urandom_range(0, 20));
        drive(1'b1, $urandom_range(3, 12));
      end else begin
        drive(1'b1, $urandom_range(0, 8));
      end
    end
    drive(1'b1, 10);
    drain(300);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
